traffic_phase_scheduler: RTL and testbench

- Single-clock, fully synchronous phase scheduler for a two-way (NS/EW) intersection.
- Sequences the green, yellow and all-red phases using a tick-gated phase timer.
- Inputs are vehicle-detect demand per direction; it ends green early (gap-out) or at a per-direction maximum (max-out).
- Drives the six lamp outputs plus phase status for downstream logic and monitoring.

---
 rtl/traffic_phase_scheduler.sv | 140 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-way (NS/EW) intersection phase scheduler: green/yellow/all-red sequencing
// with a tick-gated phase timer, gap-out on idle demand and per-direction max-out.
module traffic_phase_scheduler #(
  parameter int NS_GREEN_MAX = 31,
  parameter int EW_GREEN_MAX = 15,
  parameter int GREEN_MIN    = 4,
  parameter int YELLOW_TIME  = 3,
  parameter int ALLRED_TIME  = 1,
  parameter int CNT_W        = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_ns_detect,
  input  logic             i_ew_detect,
  output logic             o_ns_red,
  output logic             o_ns_yellow,
  output logic             o_ns_green,
  output logic             o_ew_red,
  output logic             o_ew_yellow,
  output logic             o_ew_green,
  output logic [2:0]       o_phase,
  output logic [CNT_W-1:0] o_timer,
  output logic             o_phase_done
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_t;

  localparam logic [CNT_W-1:0] NS_LAST  = CNT_W'(NS_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] EW_LAST  = CNT_W'(EW_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TIME - 1);
  // lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  localparam logic [5:0]       LAMP_RST = 6'b001_100;

  phase_t           phase_q, phase_nxt, phase_succ;
  logic [CNT_W-1:0] timer_q, timer_nxt, hold_max;
  logic             done_q, done_nxt;
  logic [5:0]       lamp_q, lamp_nxt;
  logic             leave, illegal;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase_q <= NS_GREEN;
      timer_q <= '0;
      done_q  <= 1'b0;
      lamp_q  <= LAMP_RST;
    end else begin
      phase_q <= phase_nxt;
      timer_q <= timer_nxt;
      done_q  <= done_nxt;
      lamp_q  <= lamp_nxt;
    end
  end

  // Exit condition, successor and timer ceiling for the current phase.
  // Non-green phases never reach the all-ones ceiling before they exit.
  always_comb begin
    leave      = 1'b0;
    illegal    = 1'b0;
    hold_max   = '1;
    phase_succ = NS_GREEN;
    case (phase_q)
      NS_GREEN: begin
        leave      = i_ew_detect &&
                     (timer_q == NS_LAST || (timer_q >= MIN_LAST && !i_ns_detect));
        hold_max   = NS_LAST;
        phase_succ = NS_YELLOW;
      end
      NS_YELLOW: begin
        leave      = (timer_q == YEL_LAST);
        phase_succ = ALLRED_A;
      end
      ALLRED_A: begin
        leave      = (timer_q == AR_LAST);
        phase_succ = EW_GREEN;
      end
      EW_GREEN: begin
        leave      = i_ns_detect &&
                     (timer_q == EW_LAST || (timer_q >= MIN_LAST && !i_ew_detect));
        hold_max   = EW_LAST;
        phase_succ = EW_YELLOW;
      end
      EW_YELLOW: begin
        leave      = (timer_q == YEL_LAST);
        phase_succ = ALLRED_B;
      end
      ALLRED_B: begin
        leave      = (timer_q == AR_LAST);
        phase_succ = NS_GREEN;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal codes recover without waiting for a tick.
  always_comb begin
    phase_nxt = phase_q;
    timer_nxt = timer_q;
    done_nxt  = 1'b0;
    if (illegal) begin
      phase_nxt = NS_GREEN;
      timer_nxt = '0;
      done_nxt  = 1'b1;
    end else if (i_tick) begin
      if (leave) begin
        phase_nxt = phase_succ;
        timer_nxt = '0;
        done_nxt  = 1'b1;
      end else if (timer_q != hold_max) begin
        timer_nxt = timer_q + 1'b1;
      end
    end
  end

  always_comb begin
    lamp_nxt = 6'b100_100;
    case (phase_nxt)
      NS_GREEN:  lamp_nxt = 6'b001_100;
      NS_YELLOW: lamp_nxt = 6'b010_100;
      EW_GREEN:  lamp_nxt = 6'b100_001;
      EW_YELLOW: lamp_nxt = 6'b100_010;
      default:   lamp_nxt = 6'b100_100;
    endcase
  end

  assign {o_ns_red, o_ns_yellow, o_ns_green, o_ew_red, o_ew_yellow, o_ew_green} = lamp_q;
  assign o_phase      = phase_q;
  assign o_timer      = timer_q;
  assign o_phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomized checks of traffic_phase_scheduler against a
// tick-level reference model of the phase rules.
module tb_traffic_phase_scheduler;
  localparam int NS_MAX = 31, EW_MAX = 15, GMIN = 4, YEL = 3, AR = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, tick = 1'b0, ns_det = 1'b0, ew_det = 1'b0;
  logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, done;
  logic [2:0] phase;
  logic [4:0] timer;

  int checks = 0, errors = 0;
  int m_ph = 0, m_t = 0;
  bit m_done = 1'b0;
  int dur [6] = '{NS_MAX, YEL, AR, EW_MAX, YEL, AR};

  always #5 clk = ~clk;

  traffic_phase_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick),
    .i_ns_detect(ns_det), .i_ew_detect(ew_det),
    .o_ns_red(ns_r), .o_ns_yellow(ns_y), .o_ns_green(ns_g),
    .o_ew_red(ew_r), .o_ew_yellow(ew_y), .o_ew_green(ew_g),
    .o_phase(phase), .o_timer(timer), .o_phase_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: phase i lasts dur[i] ticks when forced; greens may gap out once
  // GMIN ticks have elapsed if their own demand is gone and the other side waits.
  task automatic model_step(input bit r, input bit tk, input bit n, input bit e);
    bit go;
    m_done = 1'b0;
    if (!r) begin
      m_ph = 0; m_t = 0;
    end else if (tk) begin
      if (m_ph == 0)      go = e && (m_t == NS_MAX - 1 || (m_t >= GMIN - 1 && !n));
      else if (m_ph == 3) go = n && (m_t == EW_MAX - 1 || (m_t >= GMIN - 1 && !e));
      else                go = (m_t == dur[m_ph] - 1);
      if (go) begin
        m_ph = (m_ph + 1) % 6; m_t = 0; m_done = 1'b1;
      end else if (m_ph == 0 || m_ph == 3) begin
        m_t = (m_t + 1 < dur[m_ph]) ? m_t + 1 : dur[m_ph] - 1;
      end else begin
        m_t = m_t + 1;
      end
    end
  endtask

  task automatic check_all();
    logic [5:0] exp_lamps;
    exp_lamps = {m_ph >= 2, m_ph == 1, m_ph == 0,
                 m_ph inside {0, 1, 2, 5}, m_ph == 4, m_ph == 3};
    chk("phase", 32'(phase), 32'(m_ph));
    chk("timer", 32'(timer), 32'(m_t));
    chk("phase_done", 32'(done), 32'(m_done));
    chk("lamps", 32'({ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}), 32'(exp_lamps));
    chk("two_greens", 32'(ns_g & ew_g), 32'd0);
  endtask

  task automatic cyc(input bit r, input bit tk, input bit n, input bit e);
    rst_n = r; tick = tk; ns_det = n; ew_det = e;
    model_step(r, tk, n, e);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int cnt, ph0, k;
    #2;
    // Reset
    do_reset();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_lamps", 32'({ns_g, ew_r, ns_r, ns_y, ew_y, ew_g}), 32'b110000);

    // No demand: NS green holds with saturated timer, then ew demand ends it
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("hold_phase", 32'(phase), 32'd0);
    chk("hold_timer", 32'(timer), 32'd30);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("late_demand", 32'(phase), 32'd1);

    // Max-out: two full rounds with both detects high
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ph0 = int'(phase); cnt = 0;
      do begin cyc(1'b1, 1'b1, 1'b1, 1'b1); cnt++; end
      while (int'(phase) == ph0 && cnt < 100);
      chk("maxout_dur", 32'(cnt), 32'(dur[i % 6]));
      chk("maxout_next", 32'(phase), 32'((i + 1) % 6));
    end

    // Gap-out: NS demand absent, EW waiting
    do_reset();
    cnt = 0;
    do begin cyc(1'b1, 1'b1, 1'b0, 1'b1); cnt++; end
    while (phase == 3'd0 && cnt < 100);
    chk("gapout_dur", 32'(cnt), 32'(GMIN));
    chk("gapout_next", 32'(phase), 32'd1);

    // Tick gating: yellow with a tick every 4th clock takes 12 clocks
    do_reset();
    for (int i = 0; i < NS_MAX; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("gate_enter", 32'(phase), 32'd1);
    k = 0;
    do begin cyc(1'b1, (k % 4) == 3, 1'b1, 1'b1); k++; end
    while (phase == 3'd1 && k < 100);
    chk("gate_yellow_dur", 32'(k), 32'd12);

    // Mid-operation reset in EW_YELLOW with t=1
    do_reset();
    cnt = 0;
    while (!(phase == 3'd4 && timer == 5'd1) && cnt < 200) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1); cnt++;
    end
    chk("pre_rst_phase", 32'(phase), 32'd4);
    chk("pre_rst_timer", 32'(timer), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_exit_done", 32'(done), 32'd0);

    // Randomized traffic with sticky demand and occasional reset
    begin
      bit n, e;
      n = 1'b0; e = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) n = ~n;
        if ($urandom_range(0, 7) == 0) e = ~e;
        cyc($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0, n, e);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
